// File: rtl/store_rmw_sequencer.sv
// Read-modify-write sequencer for store instructions: reads the target doubleword,
// hands it to the external merge block, then writes the merged word back.
module store_rmw_sequencer #(
    parameter int MEM_LATENCY = 1,
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [2:0]        req_type,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] merge_base,
    output logic [DATA_W-1:0] merge_src,
    output logic [2:0]        merge_type,
    input  logic [DATA_W-1:0] merge_result,
    output logic              done,
    output logic              err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        MERGE = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        type_q, type_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            type_q  <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            type_q  <= type_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        type_d  = type_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    case (req_type)
                        3'd1: begin
                            // Full doubleword store: the old contents are irrelevant, skip the read.
                            addr_d  = req_addr;
                            data_d  = req_data;
                            type_d  = req_type;
                            state_d = MERGE;
                        end
                        3'd2, 3'd3, 3'd4: begin
                            addr_d  = req_addr;
                            data_d  = req_data;
                            type_d  = req_type;
                            cnt_d   = CNT_INIT;
                            state_d = READ;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    base_d  = mem_rdata;
                    state_d = MERGE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MERGE: begin
                wdata_d = merge_result;
                state_d = WRITE;
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write strobe is squashed during reset so an interrupted store never reaches memory.
    assign mem_wr     = (state_q == WRITE) && !reset;
    assign done       = (state_q == WRITE) && !reset;
    assign err        = err_q;
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign merge_base = base_q;
    assign merge_src  = data_q;
    assign merge_type = type_q;

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Bench for store_rmw_sequencer: two instances (read latency 1 and 3) driven with directed and
// random stores, checked every cycle against a transaction-level model.
module tb_store_rmw_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rv, rst_s;
    logic [1:0][63:0]  ra, rd;
    logic [1:0][2:0]   rt;
    logic [1:0][63:0]  mrd, mres;
    logic [1:0]        ready_w, wr_w, done_w, err_w, busy_w;
    logic [1:0][63:0]  maddr_w, wdata_w, mbase_w, msrc_w;
    logic [1:0][2:0]   mtype_w;

    logic [63:0] mem [2][64];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          lit_seq [2] = '{0, 0};
    int          lit_done[2] = '{0, 0};
    logic [63:0] lit_addr[2];
    logic [63:0] lit_data[2];

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // Little-endian store merge: the low bytes of the register replace the low bytes of memory.
    function automatic logic [63:0] merge_f(input logic [63:0] b, input logic [63:0] s,
                                            input logic [2:0] t);
        case (t)
            3'd1:    return s;
            3'd2:    return {b[63:32], s[31:0]};
            3'd3:    return {b[63:16], s[15:0]};
            3'd4:    return {b[63:8],  s[7:0]};
            default: return b;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        store_rmw_sequencer #(
            .MEM_LATENCY((g == 0) ? 1 : 3),
            .DATA_W(64),
            .ADDR_W(64)
        ) dut (
            .clk          (clk),
            .reset        (rst_s[g]),
            .req_valid    (rv[g]),
            .req_ready    (ready_w[g]),
            .req_addr     (ra[g]),
            .req_data     (rd[g]),
            .req_type     (rt[g]),
            .mem_addr     (maddr_w[g]),
            .mem_wr       (wr_w[g]),
            .mem_rdata    (mrd[g]),
            .mem_wdata    (wdata_w[g]),
            .merge_base   (mbase_w[g]),
            .merge_src    (msrc_w[g]),
            .merge_type   (mtype_w[g]),
            .merge_result (mres[g]),
            .done         (done_w[g]),
            .err          (err_w[g]),
            .busy         (busy_w[g])
        );
        assign mres[g] = merge_f(mbase_w[g], msrc_w[g], mtype_w[g]);
    end

    task automatic chk(input string nm, input int g, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", nm, g, cyc, a, e);
        end
    endtask

    // Transaction model: n counts cycles since the accepting edge (1 = first cycle after it).
    bit          act[2], isrd[2], err_e[2], chk_on[2];
    int          n[2];
    logic [63:0] m_addr[2], m_data[2], m_base[2], m_wdata[2];
    logic [2:0]  m_type[2];

    initial begin
        for (int g = 0; g < 2; g++) begin
            act[g] = 0; isrd[g] = 0; err_e[g] = 0; chk_on[g] = 0; n[g] = 0;
            m_addr[g] = '0; m_data[g] = '0; m_base[g] = '0; m_wdata[g] = '0; m_type[g] = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < 2; g++) begin
                int   L;
                int   wn;
                logic ew;
                L  = lat_of(g);
                wn = isrd[g] ? L + 2 : 2;
                if (act[g] && isrd[g] && n[g] == L)
                    mrd[g] = mem[g][m_addr[g][8:3]];
                else
                    mrd[g] = {$urandom, $urandom};
                if (chk_on[g]) begin
                    ew = act[g] && (n[g] == wn) && !rst_s[g];
                    chk("req_ready",  g, 64'(ready_w[g]), 64'(!act[g]));
                    chk("busy",       g, 64'(busy_w[g]),  64'(act[g]));
                    chk("mem_wr",     g, 64'(wr_w[g]),    64'(ew));
                    chk("done",       g, 64'(done_w[g]),  64'(ew));
                    chk("err",        g, 64'(err_w[g]),   64'(err_e[g]));
                    chk("mem_addr",   g, maddr_w[g],      m_addr[g]);
                    chk("merge_src",  g, msrc_w[g],       m_data[g]);
                    chk("merge_type", g, 64'(mtype_w[g]), 64'(m_type[g]));
                    chk("merge_base", g, mbase_w[g],      m_base[g]);
                    chk("mem_wdata",  g, wdata_w[g],      m_wdata[g]);
                    if (ew && lit_seq[g] != lit_done[g]) begin
                        chk("lit_addr",  g, maddr_w[g], lit_addr[g]);
                        chk("lit_wdata", g, wdata_w[g], lit_data[g]);
                        lit_done[g] = lit_seq[g];
                    end
                end
                if (rst_s[g]) begin
                    act[g] = 0; n[g] = 0; err_e[g] = 0; chk_on[g] = 1;
                    m_addr[g] = '0; m_data[g] = '0; m_base[g] = '0; m_wdata[g] = '0; m_type[g] = '0;
                end else if (!act[g]) begin
                    err_e[g] = 0;
                    if (rv[g]) begin
                        if (rt[g] >= 3'd1 && rt[g] <= 3'd4) begin
                            act[g] = 1; n[g] = 1; isrd[g] = (rt[g] != 3'd1);
                            m_addr[g] = ra[g]; m_data[g] = rd[g]; m_type[g] = rt[g];
                        end else begin
                            err_e[g] = 1;
                        end
                    end
                end else begin
                    err_e[g] = 0;
                    if (isrd[g] && n[g] == L) m_base[g] = mem[g][m_addr[g][8:3]];
                    if (n[g] == wn - 1) m_wdata[g] = merge_f(m_base[g], m_data[g], m_type[g]);
                    if (n[g] == wn) act[g] = 0;
                    else n[g] = n[g] + 1;
                end
            end
        end
    end

    task automatic issue(input int g, input logic [2:0] t, input logic [63:0] a,
                         input logic [63:0] d, input int hold);
        logic r;
        r = 1'b0;
        rv[g] = 1'b1; rt[g] = t; ra[g] = a; rd[g] = d;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            r = ready_w[g];
            @(posedge clk);
            #1;
            if (r) break;
        end
        if (!r) begin
            $display("FAIL issue_timeout inst=%0d got=ready_low exp=ready_high", g);
            $fatal(1, "request never accepted");
        end
        for (int h = 0; h < hold; h++) begin
            rd[g] = {$urandom, $urandom};
            ra[g] = 64'({$urandom_range(0, 63), 3'b000});
            rt[g] = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        rv[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        logic r;
        r = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            r = ready_w[g];
            if (r) break;
        end
        if (!r) begin
            $display("FAIL idle_timeout inst=%0d got=busy exp=idle", g);
            $fatal(1, "sequencer never returned to idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int g);
        rst_s[g] = 1'b1;
        @(posedge clk);
        #1;
        rst_s[g] = 1'b0;
    endtask

    initial begin
        rv = '0; rst_s = 2'b11; ra = '0; rd = '0; rt = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 64; j++)
                mem[i][j] = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        #1;
        rst_s = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // sw with one-cycle memory
        mem[0][8] = 64'h1111_2222_3333_4444;
        lit_addr[0] = 64'h40; lit_data[0] = 64'h1111_2222_1234_5678; lit_seq[0]++;
        issue(0, 3'd2, 64'h40, 64'hAAAA_BBBB_1234_5678, 0);
        wait_idle(0);

        // sd skips the read
        lit_addr[0] = 64'h08; lit_data[0] = 64'hDEAD_BEEF_CAFE_F00D; lit_seq[0]++;
        issue(0, 3'd1, 64'h08, 64'hDEAD_BEEF_CAFE_F00D, 0);
        wait_idle(0);

        // illegal type
        issue(0, 3'd5, 64'h18, 64'h1234, 0);
        repeat (3) @(posedge clk);
        #1;

        // request held high with changing data during a sw
        mem[0][2] = 64'h0123_4567_89AB_CDEF;
        lit_addr[0] = 64'h10; lit_data[0] = 64'h0123_4567_7777_8888; lit_seq[0]++;
        issue(0, 3'd2, 64'h10, 64'h5555_6666_7777_8888, 7);
        wait_idle(0);

        // sb with three-cycle memory
        mem[1][16] = 64'h0;
        lit_addr[1] = 64'h80; lit_data[1] = 64'h0000_0000_0000_00FF; lit_seq[1]++;
        issue(1, 3'd4, 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        wait_idle(1);

        // sh interrupted by reset in MERGE, then a clean sh
        issue(1, 3'd3, 64'h20, 64'h9999_8888_7777_6666, 0);
        repeat (3) @(posedge clk);
        #1;
        pulse_reset(1);
        repeat (2) @(posedge clk);
        #1;
        mem[1][32] = 64'hAAAA_AAAA_AAAA_AAAA;
        lit_addr[1] = 64'h100; lit_data[1] = 64'hAAAA_AAAA_AAAA_1234; lit_seq[1]++;
        issue(1, 3'd3, 64'h100, 64'h5678_1234, 0);
        wait_idle(1);

        for (int it = 0; it < 400; it++) begin
            int          g;
            logic [2:0]  t;
            g = int'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 7) t = 3'($urandom_range(1, 4));
            else t = 3'($urandom_range(0, 7));
            issue(g, t, 64'({$urandom_range(0, 63), 3'b000}), {$urandom, $urandom},
                  ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 8)) : 0);
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1;
                pulse_reset(g);
            end
            wait_idle(g);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
